shuffle_buffer: RTL and testbench

//   Storage stage of the shuffle path, directly upstream of the index mapper.

---
 rtl/shuffle_buffer_if.sv | 27 ++
 rtl/shuffle_buffer.sv | 79 +++++++
 tb/tb_shuffle_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/shuffle_buffer_if.sv
// Handshake bundle between the stream source, the shuffle buffer and the index mapper.
interface shuffle_buffer_if #(
  parameter int bs = 16,
  parameter int DW = 8
);
  logic                   in_valid;
  logic [DW-1:0]          in_data;
  logic                   in_ready;
  logic                   flush;
  logic [bs-1:0]          cand_list;
  logic                   start;
  logic [$clog2(bs)-1:0]  buffer_index;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic                   out_ready;
  logic [$clog2(bs):0]    count;

  modport slave (
    input  in_valid, in_data, flush, buffer_index, out_ready,
    output in_ready, cand_list, start, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, flush, buffer_index, out_ready,
    input  in_ready, cand_list, start, out_valid, out_data, count
  );
endinterface

// File: rtl/shuffle_buffer.sv
// Slot buffer feeding the index mapper: fills bs words, pops the mapper-selected slot,
// refills freed slots from the input stream, and drains everything on flush.
module shuffle_buffer #(
  parameter int bs = 16,
  parameter int DW = 8
) (
  input logic             clk,
  input logic             rst,
  shuffle_buffer_if.slave bus
);
  localparam int IW = $clog2(bs);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t         state, state_next;
  logic [bs-1:0]  occ, occ_next;
  logic [CW-1:0]  count, count_next;
  logic [DW-1:0]  mem [bs];
  logic [IW-1:0]  free_idx;
  logic           found;
  logic           push, pop;

  // Lowest-index empty slot, taken from occupancy at the start of the cycle.
  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < bs; i++) begin
      if (!occ[i] && !found) begin
        free_idx = IW'(i);
        found    = 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state != FLUSH) && !(&occ);
  assign bus.out_valid = (state != FILL) && occ[bus.buffer_index];
  assign bus.out_data  = mem[bus.buffer_index];
  assign bus.cand_list = occ;
  assign bus.count     = count;
  assign bus.start     = (state != FILL);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Push target is always empty and the pop slot always occupied, so they never collide.
  always_comb begin
    occ_next = occ;
    if (pop)  occ_next[bus.buffer_index] = 1'b0;
    if (push) occ_next[free_idx] = 1'b1;
    count_next = count + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    if (&occ_next) state_next = RUN;
      RUN:     if (bus.flush) state_next = FLUSH;
      FLUSH:   if (occ_next == '0) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      occ   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      occ   <= occ_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[free_idx] <= bus.in_data;
  end
endmodule

// File: tb/tb_shuffle_buffer.sv
// Directed bench for shuffle_buffer (bs=16, DW=8): fill, pop, refill, flush drain, reset.
module tb_shuffle_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;
  logic [7:0] exp_mem [16];

  always #5 clk = ~clk;

  shuffle_buffer_if #(.bs(16), .DW(8)) bus ();

  shuffle_buffer #(.bs(16), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.flush        = 1'b0;
    bus.buffer_index = '0;
    bus.out_ready    = 1'b0;

    // Test 1: reset then idle
    step(); step();
    rst = 1'b0;
    step();
    chk("t1_cand", bus.cand_list, 16'h0000);
    chk("t1_count", bus.count, 0);
    chk("t1_start", bus.start, 0);
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_in_ready", bus.in_ready, 1);

    // Test 2: fill 0x10..0x1F
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h10 + i);
      exp_mem[i]   = 8'(8'h10 + i);
      if (i == 15) chk("t2_start_before_full", bus.start, 0);
      step();
    end
    bus.in_valid = 1'b0;
    chk("t2_cand", bus.cand_list, 16'hFFFF);
    chk("t2_count", bus.count, 16);
    chk("t2_start", bus.start, 1);
    chk("t2_in_ready", bus.in_ready, 0);

    // Push while full is refused
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    step();
    bus.in_valid = 1'b0;
    chk("t2_full_push_count", bus.count, 16);
    for (int i = 0; i < 16; i++) begin
      bus.buffer_index = 4'(i);
      #1;
      chk($sformatf("t2_slot%0d", i), bus.out_data, exp_mem[i]);
      chk($sformatf("t2_valid%0d", i), bus.out_valid, 1);
    end

    // Test 3: pop slot 5, refill it
    bus.buffer_index = 4'd5;
    bus.out_ready    = 1'b1;
    #1;
    chk("t3_out_data", bus.out_data, 8'h15);
    chk("t3_out_valid", bus.out_valid, 1);
    step();
    bus.out_ready = 1'b0;
    #1;
    chk("t3_cand", bus.cand_list, 16'hFFDF);
    chk("t3_count", bus.count, 15);
    chk("t3_in_ready", bus.in_ready, 1);
    chk("t3_bubble", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    exp_mem[5]   = 8'hAA;
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("t3_cand_refill", bus.cand_list, 16'hFFFF);
    chk("t3_slot5", bus.out_data, 8'hAA);

    // Test 4: free slot 3, then simultaneous pop of 7 and push of 0x55
    bus.buffer_index = 4'd3;
    bus.out_ready    = 1'b1;
    step();
    chk("t4_cand_pre", bus.cand_list, 16'hFFF7);
    bus.buffer_index = 4'd7;
    bus.in_valid     = 1'b1;
    bus.in_data      = 8'h55;
    exp_mem[3]       = 8'h55;
    #1;
    chk("t4_pop_data", bus.out_data, 8'h17);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("t4_cand", bus.cand_list, 16'hFF7F);
    chk("t4_count", bus.count, 15);
    bus.buffer_index = 4'd3;
    #1;
    chk("t4_slot3", bus.out_data, 8'h55);

    // Refill slot 7 so the buffer is full again
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    exp_mem[7]   = 8'h77;
    step();
    bus.in_valid = 1'b0;
    chk("t5_pre_count", bus.count, 16);

    // Test 5: flush drain, with input offered throughout
    bus.in_valid     = 1'b1;
    bus.in_data      = 8'hCC;
    bus.flush        = 1'b1;
    bus.out_ready    = 1'b1;
    bus.buffer_index = 4'd0;
    #1;
    chk("t5_pop0", bus.out_data, exp_mem[0]);
    step();
    bus.flush = 1'b0;
    for (int i = 1; i < 16; i++) begin
      bus.buffer_index = 4'(i);
      #1;
      chk($sformatf("t5_in_ready%0d", i), bus.in_ready, 0);
      chk($sformatf("t5_valid%0d", i), bus.out_valid, 1);
      chk($sformatf("t5_pop%0d", i), bus.out_data, exp_mem[i]);
      chk($sformatf("t5_start%0d", i), bus.start, 1);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("t5_count", bus.count, 0);
    chk("t5_cand", bus.cand_list, 16'h0000);
    chk("t5_start", bus.start, 0);
    chk("t5_in_ready", bus.in_ready, 1);

    // Flush in FILL is ignored
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t5_fill_flush_start", bus.start, 0);
    chk("t5_fill_flush_ready", bus.in_ready, 1);

    // Test 6: reset mid-RUN at count=12
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.buffer_index = 4'(i);
      step();
    end
    bus.out_ready = 1'b0;
    chk("t6_pre_count", bus.count, 12);
    chk("t6_pre_start", bus.start, 1);
    rst              = 1'b1;
    bus.in_valid     = 1'b1;
    bus.out_ready    = 1'b1;
    bus.buffer_index = 4'd8;
    step();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("t6_cand", bus.cand_list, 16'h0000);
    chk("t6_count", bus.count, 0);
    chk("t6_start", bus.start, 0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_in_ready", bus.in_ready, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
